// File: rtl/stage_execute_multdiv.sv
// stage_execute_multdiv: execute stage with an iterative 32-cycle multiply/divide unit feeding the X/M latch
module stage_execute_multdiv (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] insn_in,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] alu_in,
  output logic [31:0] o_out,
  output logic [31:0] b_out,
  output logic [31:0] insn_out,
  output logic        md_exception,
  output logic        stall
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] mag;
  logic        neg, is_div, dz;
  logic        is_md, md_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, diff;
  logic [63:0] mul_next, sh, div_next;
  logic [31:0] mul_res, div_res;
  logic        mul_ovf, div_flag;
  assign is_md  = insn_in[31:27] == 5'b0 && insn_in[6:3] == 4'b0011;
  assign md_div = insn_in[2];
  assign a_mag  = a_in[31] ? -a_in : a_in;
  assign b_mag  = b_in[31] ? -b_in : b_in;
  // mul: acc holds {partial sum, remaining multiplier bits}, shifted right each step
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  // div: acc holds {remainder, dividend/quotient}; restore by keeping the unsubtracted shift
  assign sh       = {acc[62:0], 1'b0};
  assign diff     = {1'b0, sh[63:32]} - {1'b0, mag};
  assign div_next = diff[32] ? sh : {diff[31:0], sh[31:1], 1'b1};
  assign mul_res  = neg ? -acc[31:0] : acc[31:0];
  assign mul_ovf  = |acc[63:32] || (acc[31] && (!neg || |acc[30:0]));
  assign div_res  = dz ? 32'd0 : mul_res;
  assign div_flag = dz || (!neg && acc[31]);
  assign stall    = resetn && (state == MUL || state == DIV || (state == IDLE && is_md));
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      o_out        <= 32'd0;
      b_out        <= 32'd0;
      insn_out     <= 32'd0;
      md_exception <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_md) begin
            mag          <= md_div ? b_mag : a_mag;
            acc          <= {32'd0, md_div ? a_mag : b_mag};
            neg          <= a_in[31] ^ b_in[31];
            is_div       <= md_div;
            dz           <= md_div && b_in == 32'd0;
            cnt          <= 5'd0;
            state        <= !md_div ? MUL : (b_in == 32'd0 ? DONE : DIV);
            o_out        <= 32'd0;
            b_out        <= 32'd0;
            insn_out     <= 32'd0;
            md_exception <= 1'b0;
          end else begin
            o_out        <= alu_in;
            b_out        <= b_in;
            insn_out     <= insn_in;
            md_exception <= 1'b0;
          end
        end
        MUL, DIV: begin
          acc          <= state == MUL ? mul_next : div_next;
          cnt          <= cnt + 5'd1;
          state        <= cnt == 5'd31 ? DONE : state;
          o_out        <= 32'd0;
          b_out        <= 32'd0;
          insn_out     <= 32'd0;
          md_exception <= 1'b0;
        end
        default: begin
          o_out        <= is_div ? div_res : mul_res;
          b_out        <= b_in;
          insn_out     <= insn_in;
          md_exception <= is_div ? div_flag : mul_ovf;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule
